// File: rtl/tc_lat_bridge_pkg.sv
// Shared types and constants for the latency-RAM request/response bridge.
// Read-timeout watchdog is enabled by defining TC_LAT_BRIDGE_TIMEOUT_EN.
package tc_lat_bridge_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RESP
    } state_e;

    localparam int TIMEOUT_DEFAULT = 16;
    localparam int WDOG_WIDTH      = 8;
    localparam int N_WORDS         = 4;

endpackage

// File: rtl/tc_lat_bridge_wdog.sv
// Read-wait watchdog: counts enabled cycles, flags expiry on the LIMIT-th one.
// Only instantiated when TC_LAT_BRIDGE_TIMEOUT_EN is defined.
module tc_lat_bridge_wdog
    import tc_lat_bridge_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_DEFAULT,
    parameter int WIDTH = WDOG_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [WIDTH-1:0] LP_LAST = WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Expiry lands on the edge that ends the LIMIT-th enabled cycle.
    assign o_expired = i_enable && (r_count >= LP_LAST);

endmodule

// File: rtl/tc_lat_mem_bridge.sv
// Four-word request/response bridge onto a latency RAM (save/load strobes).
// Define TC_LAT_BRIDGE_TIMEOUT_EN to bound RD_WAIT with an error response.
module tc_lat_mem_bridge
    import tc_lat_bridge_pkg::*;
#(
    parameter int BIT_WIDTH = 16,
    parameter int TIMEOUT   = TIMEOUT_DEFAULT,
    parameter int UUID      = 0,
    parameter     NAME      = ""
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [15:0]          req_addr,
    input  logic [BIT_WIDTH-1:0] req_wdata0,
    input  logic [BIT_WIDTH-1:0] req_wdata1,
    input  logic [BIT_WIDTH-1:0] req_wdata2,
    input  logic [BIT_WIDTH-1:0] req_wdata3,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [BIT_WIDTH-1:0] rsp_data0,
    output logic [BIT_WIDTH-1:0] rsp_data1,
    output logic [BIT_WIDTH-1:0] rsp_data2,
    output logic [BIT_WIDTH-1:0] rsp_data3,
    output logic                 rsp_err,
    output logic                 mem_load,
    output logic                 mem_save,
    output logic [15:0]          mem_address,
    output logic [BIT_WIDTH-1:0] mem_in0,
    output logic [BIT_WIDTH-1:0] mem_in1,
    output logic [BIT_WIDTH-1:0] mem_in2,
    output logic [BIT_WIDTH-1:0] mem_in3,
    input  logic                 mem_ready,
    input  logic [BIT_WIDTH-1:0] mem_out0,
    input  logic [BIT_WIDTH-1:0] mem_out1,
    input  logic [BIT_WIDTH-1:0] mem_out2,
    input  logic [BIT_WIDTH-1:0] mem_out3
);

    if (UUID < 0 || TIMEOUT < 0 || NAME == "?") begin : g_param_ref
    end

    state_e               r_state;
    logic                 r_mem_load;
    logic                 r_mem_save;
    logic [15:0]          r_mem_addr;
    logic [BIT_WIDTH-1:0] r_mem_in   [N_WORDS];
    logic                 r_rsp_valid;
    logic [BIT_WIDTH-1:0] r_rsp_data [N_WORDS];
    logic                 r_rsp_err;
    logic                 w_expired;

`ifdef TC_LAT_BRIDGE_TIMEOUT_EN
    tc_lat_bridge_wdog #(
        .LIMIT (TIMEOUT),
        .WIDTH (WDOG_WIDTH)
    ) u_wdog (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (r_state != S_RD_WAIT),
        .i_enable  (r_state == S_RD_WAIT),
        .o_expired (w_expired)
    );
`else
    assign w_expired = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mem_load  <= 1'b0;
            r_mem_save  <= 1'b0;
            r_mem_addr  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            for (int i = 0; i < N_WORDS; i++) begin
                r_mem_in[i]   <= '0;
                r_rsp_data[i] <= '0;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_mem_addr <= req_addr;
                        if (req_write) begin
                            r_state     <= S_WR;
                            r_mem_save  <= 1'b1;
                            r_mem_in[0] <= req_wdata0;
                            r_mem_in[1] <= req_wdata1;
                            r_mem_in[2] <= req_wdata2;
                            r_mem_in[3] <= req_wdata3;
                        end else begin
                            r_state    <= S_RD_ISSUE;
                            r_mem_load <= 1'b1;
                        end
                    end
                end
                S_WR: begin
                    r_state     <= S_RESP;
                    r_mem_save  <= 1'b0;
                    r_mem_addr  <= '0;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    for (int i = 0; i < N_WORDS; i++) begin
                        r_mem_in[i]   <= '0;
                        r_rsp_data[i] <= '0;
                    end
                end
                S_RD_ISSUE: begin
                    r_state    <= S_RD_WAIT;
                    r_mem_load <= 1'b0;
                end
                S_RD_WAIT: begin
                    // A real return wins over an expiry on the same edge.
                    if (mem_ready) begin
                        r_state       <= S_RESP;
                        r_mem_addr    <= '0;
                        r_rsp_valid   <= 1'b1;
                        r_rsp_err     <= 1'b0;
                        r_rsp_data[0] <= mem_out0;
                        r_rsp_data[1] <= mem_out1;
                        r_rsp_data[2] <= mem_out2;
                        r_rsp_data[3] <= mem_out3;
                    end else if (w_expired) begin
                        r_state     <= S_RESP;
                        r_mem_addr  <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        for (int i = 0; i < N_WORDS; i++) begin
                            r_rsp_data[i] <= '0;
                        end
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        for (int i = 0; i < N_WORDS; i++) begin
                            r_rsp_data[i] <= '0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready   = (r_state == S_IDLE) && !rst;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_err     = r_rsp_err;
    assign rsp_data0   = r_rsp_data[0];
    assign rsp_data1   = r_rsp_data[1];
    assign rsp_data2   = r_rsp_data[2];
    assign rsp_data3   = r_rsp_data[3];
    assign mem_load    = r_mem_load;
    assign mem_save    = r_mem_save;
    assign mem_address = r_mem_addr;
    assign mem_in0     = r_mem_in[0];
    assign mem_in1     = r_mem_in[1];
    assign mem_in2     = r_mem_in[2];
    assign mem_in3     = r_mem_in[3];

endmodule

// File: tb/tb_tc_lat_mem_bridge.sv
// Bench for tc_lat_mem_bridge: vector table, corner sequences, random traffic.
module tb_tc_lat_mem_bridge;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_write;
    logic [15:0]   req_addr;
    logic [W-1:0]  req_wdata0, req_wdata1, req_wdata2, req_wdata3;
    logic          rsp_valid, rsp_ready, rsp_err;
    logic [W-1:0]  rsp_data0, rsp_data1, rsp_data2, rsp_data3;
    logic          mem_load, mem_save, mem_ready;
    logic [15:0]   mem_address;
    logic [W-1:0]  mem_in0, mem_in1, mem_in2, mem_in3;
    logic [W-1:0]  mem_out0, mem_out1, mem_out2, mem_out3;

    always #5 clk = ~clk;

    tc_lat_mem_bridge #(.BIT_WIDTH(W), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .req_wdata2(req_wdata2), .req_wdata3(req_wdata3),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
        .rsp_data2(rsp_data2), .rsp_data3(rsp_data3),
        .rsp_err(rsp_err),
        .mem_load(mem_load), .mem_save(mem_save), .mem_address(mem_address),
        .mem_in0(mem_in0), .mem_in1(mem_in1), .mem_in2(mem_in2), .mem_in3(mem_in3),
        .mem_ready(mem_ready),
        .mem_out0(mem_out0), .mem_out1(mem_out1),
        .mem_out2(mem_out2), .mem_out3(mem_out3)
    );

    logic [W-1:0] mi [4];
    logic [W-1:0] rd [4];
    assign mi[0] = mem_in0;  assign mi[1] = mem_in1;
    assign mi[2] = mem_in2;  assign mi[3] = mem_in3;
    assign rd[0] = rsp_data0; assign rd[1] = rsp_data1;
    assign rd[2] = rsp_data2; assign rd[3] = rsp_data3;

    int n_cmp = 0;
    int n_bad = 0;
    int both_hi = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) if (mem_save && mem_load) both_hi++;

    // Latency RAM: ready with data two cycles after the cycle load is seen.
    logic [W-1:0] ram     [65536];
    logic [W-1:0] ref_mem [65536];
    bit           ram_mute = 1'b0;
    int           cd = 0;
    logic [15:0]  ra;

    initial begin
        mem_ready = 1'b0;
        mem_out0 = '0; mem_out1 = '0; mem_out2 = '0; mem_out3 = '0;
        forever begin
            @(posedge clk); #1;
            if (cd > 0) begin
                cd--;
                if (cd == 0 && !ram_mute) begin
                    mem_ready = 1'b1;
                    mem_out0 = ram[ra];
                    mem_out1 = ram[16'(ra + 16'd1)];
                    mem_out2 = ram[16'(ra + 16'd2)];
                    mem_out3 = ram[16'(ra + 16'd3)];
                end
            end else begin
                mem_ready = 1'b0;
                mem_out0 = '0; mem_out1 = '0; mem_out2 = '0; mem_out3 = '0;
            end
            if (mem_save) begin
                for (int i = 0; i < 4; i++) ram[16'(mem_address + 16'(i))] = mi[i];
            end
            if (mem_load) begin
                cd = 2;
                ra = mem_address;
            end
        end
    end

    // n counts clock edges from the acceptance edge (inclusive) to rsp_valid.
    task automatic txn(input bit wr, input logic [15:0] a, input logic [W-1:0] wd [4],
                       input int exp_lat, input logic [W-1:0] ed [4], input bit eerr,
                       input string tag);
        int n, saves, loads;
        req_write = wr; req_addr = a;
        req_wdata0 = wd[0]; req_wdata1 = wd[1]; req_wdata2 = wd[2]; req_wdata3 = wd[3];
        req_valid = 1'b1;
        chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 1; saves = 0; loads = 0;
        while (!rsp_valid && n < 64) begin
            if (mem_save) begin
                saves++;
                chk({tag, ".save_addr"}, 32'(mem_address), 32'(a));
                for (int i = 0; i < 4; i++)
                    chk($sformatf("%s.mem_in%0d", tag, i), 32'(mi[i]), 32'(wd[i]));
            end
            if (mem_load) begin
                loads++;
                chk({tag, ".load_addr"}, 32'(mem_address), 32'(a));
            end
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".latency"}, 32'(n), 32'(exp_lat));
        chk({tag, ".saves"}, 32'(saves), wr ? 32'd1 : 32'd0);
        chk({tag, ".loads"}, 32'(loads), wr ? 32'd0 : 32'd1);
        chk({tag, ".rsp_err"}, 32'(rsp_err), 32'(eerr));
        chk({tag, ".req_ready_busy"}, 32'(req_ready), 32'd0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s.rsp_data%0d", tag, i), 32'(rd[i]), 32'(ed[i]));
    endtask

    task automatic finish_rsp(input string tag);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, ".rsp_drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".req_ready_back"}, 32'(req_ready), 32'd1);
    endtask

    typedef struct {
        bit          wr;
        logic [15:0] a;
        logic [W-1:0] wd [4];
        int          lat;
        logic [W-1:0] ed [4];
    } vec_t;

    vec_t         v [7];
    logic [W-1:0] z4 [4];
    logic [W-1:0] wd [4];
    logic [W-1:0] ed [4];
    bit           wr;
    logic [15:0]  a;
    bit           seen;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i] = '0;
            ref_mem[i] = '0;
        end
        for (int i = 0; i < 4; i++) z4[i] = '0;

        v[0] = '{1'b1, 16'h0010, '{16'd1, 16'd2, 16'd3, 16'd4}, 2, '{16'd0, 16'd0, 16'd0, 16'd0}};
        v[1] = '{1'b0, 16'h0010, '{16'd0, 16'd0, 16'd0, 16'd0}, 4, '{16'd1, 16'd2, 16'd3, 16'd4}};
        v[2] = '{1'b1, 16'hFFFE, '{16'd5, 16'd6, 16'd7, 16'd8}, 2, '{16'd0, 16'd0, 16'd0, 16'd0}};
        v[3] = '{1'b0, 16'hFFFE, '{16'd0, 16'd0, 16'd0, 16'd0}, 4, '{16'd5, 16'd6, 16'd7, 16'd8}};
        v[4] = '{1'b0, 16'h0000, '{16'd0, 16'd0, 16'd0, 16'd0}, 4, '{16'd7, 16'd8, 16'd0, 16'd0}};
        v[5] = '{1'b1, 16'h0011, '{16'hA, 16'hB, 16'hC, 16'hD}, 2, '{16'd0, 16'd0, 16'd0, 16'd0}};
        v[6] = '{1'b0, 16'h0010, '{16'd0, 16'd0, 16'd0, 16'd0}, 4, '{16'd1, 16'hA, 16'hB, 16'hC}};

        rst = 1'b1; rsp_ready = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0;
        req_wdata0 = '0; req_wdata1 = '0; req_wdata2 = '0; req_wdata3 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset.mem_load", 32'(mem_load), 32'd0);
        chk("reset.mem_save", 32'(mem_save), 32'd0);
        chk("reset.mem_address", 32'(mem_address), 32'd0);
        chk("reset.rsp_data0", 32'(rsp_data0), 32'd0);
        rst = 1'b0;
        #1;
        chk("reset.req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        for (int k = 0; k < 7; k++) begin
            txn(v[k].wr, v[k].a, v[k].wd, v[k].lat, v[k].ed, 1'b0, $sformatf("vec%0d", k));
            if (v[k].wr)
                for (int i = 0; i < 4; i++) ref_mem[16'(v[k].a + 16'(i))] = v[k].wd[i];
            finish_rsp($sformatf("vec%0d", k));
        end

        // Response held for five cycles, then back-to-back request on exit.
        for (int i = 0; i < 4; i++) ed[i] = ref_mem[16'(16'h0010 + 16'(i))];
        txn(1'b0, 16'h0010, z4, 4, ed, 1'b0, "hold");
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("hold%0d.rsp_valid", c), 32'(rsp_valid), 32'd1);
            chk($sformatf("hold%0d.rsp_data1", c), 32'(rsp_data1), 32'(ed[1]));
            chk($sformatf("hold%0d.req_ready", c), 32'(req_ready), 32'd0);
        end
        req_write = 1'b1; req_addr = 16'h0040;
        req_wdata0 = 16'h9; req_wdata1 = 16'h19; req_wdata2 = 16'h29; req_wdata3 = 16'h39;
        req_valid = 1'b1; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("b2b.exit_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("b2b.not_accepted", 32'(mem_save), 32'd0);
        chk("b2b.req_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("b2b.save", 32'(mem_save), 32'd1);
        chk("b2b.mem_in3", 32'(mem_in3), 32'h39);
        @(posedge clk); #1;
        chk("b2b.rsp_valid", 32'(rsp_valid), 32'd1);
        ref_mem[16'h0040] = 16'h9;  ref_mem[16'h0041] = 16'h19;
        ref_mem[16'h0042] = 16'h29; ref_mem[16'h0043] = 16'h39;
        finish_rsp("b2b");

        // Reset in RD_WAIT; the RAM's late ready must be ignored.
        req_write = 1'b0; req_addr = 16'h0010; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rstmid.load", 32'(mem_load), 32'd1);
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        chk("rstmid.mem_address", 32'(mem_address), 32'd0);
        chk("rstmid.mem_load", 32'(mem_load), 32'd0);
        chk("rstmid.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstmid.req_ready", 32'(req_ready), 32'd0);
        #1 rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        chk("rstmid.no_rsp", 32'(seen), 32'd0);
        chk("rstmid.req_ready", 32'(req_ready), 32'd1);

        ram_mute = 1'b1;
`ifdef TC_LAT_BRIDGE_TIMEOUT_EN
        txn(1'b0, 16'h0020, z4, 18, z4, 1'b1, "timeout");
        finish_rsp("timeout");
`else
        req_write = 1'b0; req_addr = 16'h0020; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (rsp_valid || rsp_err) seen = 1'b1;
        end
        chk("nowdog.waits", 32'(seen), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
`endif
        ram_mute = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 40; k++) begin
            wr = 1'($urandom_range(0, 1));
            a = 16'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) a = a + 16'hFFF0;
            for (int i = 0; i < 4; i++) begin
                wd[i] = W'($urandom);
                ed[i] = wr ? '0 : ref_mem[16'(a + 16'(i))];
            end
            txn(wr, a, wd, wr ? 2 : 4, ed, 1'b0, $sformatf("rnd%0d", k));
            if (wr)
                for (int i = 0; i < 4; i++) ref_mem[16'(a + 16'(i))] = wd[i];
            finish_rsp($sformatf("rnd%0d", k));
        end

        chk("save_load_exclusive", 32'(both_hi), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tc_lat_mem_bridge.md
TC_LAT_MEM_BRIDGE -- requirements
Module: tc_lat_mem_bridge

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 16, width of each data word.
REQ-002 SHALL have parameter TIMEOUT, default 16, max RD_WAIT cycles before error (used only with the macro).
REQ-003 SHALL have parameters UUID (default 0) and NAME (default ""), both unused in logic.
REQ-004 clk  input  1  single clock; all state updates on posedge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  requester has a transaction.
REQ-007 req_ready  output  1  bridge can accept.
REQ-008 req_write  input  1  1=write 4 words, 0=read 4 words.
REQ-009 req_addr  input  16  base word address.
REQ-010 req_wdata0..req_wdata3  input  BIT_WIDTH each  write words.
REQ-011 rsp_valid  output  1  response available.
REQ-012 rsp_ready  input  1  requester consumes response.
REQ-013 rsp_data0..rsp_data3  output  BIT_WIDTH each  read words (zero for writes).
REQ-014 rsp_err  output  1  transaction timed out.
REQ-015 mem_load, mem_save  output  1 each  downstream latency-RAM strobes.
REQ-016 mem_address  output  16  downstream address.
REQ-017 mem_in0..mem_in3  output  BIT_WIDTH each  downstream write words.
REQ-018 mem_ready  input  1; mem_out0..mem_out3  input  BIT_WIDTH each  downstream read return.

Function
REQ-019 FSM states SHALL be IDLE, WR, RD_ISSUE, RD_WAIT, RESP; req_ready=1 only in IDLE.
REQ-020 Acceptance = req_valid&&req_ready at posedge; SHALL latch addr, write flag, wdata; next state WR if write, else RD_ISSUE.
REQ-021 WR: mem_save=1 for exactly one cycle, mem_address/mem_in* = latched values; next state RESP.
REQ-022 RD_ISSUE: mem_load=1 for exactly one cycle, mem_address = latched addr; next state RD_WAIT.
REQ-023 RD_WAIT: mem_load=0, mem_address held; on mem_ready=1 SHALL capture mem_out0..3 into rsp_data0..3 and go to RESP.
REQ-024 Read latency: rsp_valid SHALL rise 4 clock edges after the acceptance edge with a 2-cycle-latency RAM.
REQ-025 Write latency: rsp_valid SHALL rise 2 edges after acceptance; rsp_data0..3 = 0.
REQ-026 RESP: rsp_valid=1 and rsp_data/rsp_err stable until rsp_ready=1; that edge returns to IDLE.
REQ-027 Back-to-back: new request SHALL NOT be accepted in the RESP-exit cycle (req_ready rises the cycle after).
REQ-028 mem_ready outside RD_WAIT SHALL be ignored; mem_load and mem_save SHALL never be high together.
REQ-029 Addresses pass unmodified; wrap of addr+1..addr+3 is the RAM's concern, no alignment check.
REQ-030 Outside WR/RD_ISSUE/RD_WAIT, mem_address and mem_in* SHALL be 0.

Reset
REQ-031 On rst (any time, incl. mid-transaction): state IDLE, pending transaction dropped, all outputs 0 except req_ready=1 after release.
REQ-032 Latched registers and captured data SHALL clear to 0.

Configuration
REQ-033 Macro TC_LAT_BRIDGE_TIMEOUT_EN defined: 8-bit counter counts RD_WAIT cycles; reaching TIMEOUT without mem_ready SHALL go to RESP with rsp_err=1, rsp_data=0.
REQ-034 Macro undefined: no counter, RD_WAIT waits indefinitely, rsp_err tied 0.

Structure
REQ-035 Package tc_lat_bridge_pkg SHALL hold the state enum and TIMEOUT default constant.
REQ-036 Sub-module tc_lat_bridge_wdog (clear/enable/expired counter) SHALL implement the timeout, instantiated only under the macro.

Verification
REQ-037 Write addr=0x0010, wdata=1,2,3,4 -> mem_save one cycle, mem_in=1,2,3,4; rsp_valid 2 edges after accept, rsp_err=0.
REQ-038 Read addr=0x0010 after that write, RAM model latency 2 -> mem_load one cycle; rsp_data=1,2,3,4 4 edges after accept.
REQ-039 Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_data stable, req_ready=0 throughout.
REQ-040 rst asserted during RD_WAIT -> outputs 0 asynchronously; late mem_ready after release produces no rsp_valid.
REQ-041 With TC_LAT_BRIDGE_TIMEOUT_EN, TIMEOUT=16, mem_ready never asserted -> rsp_valid with rsp_err=1 after 16 RD_WAIT cycles.
REQ-042 Read addr=0xFFFE -> mem_address=0xFFFE passed unmodified, response returned normally.
